icb_apb_bridge: RTL

Single-outstanding bridge from the core's ICB peripheral bus to an APB3 slave port such as the APB UART. Sits directly upstream of the UART and drives its PADDR/PWDATA/PWRITE/PSEL/PENABLE, then returns PRDATA/PSLVERR as an ICB response. Handles wait states via PREADY, suppresses null writes, and terminates hung transfers with a timeout error.

---
 rtl/icb_apb_bridge.sv | 137 +++++++++++++
 1 files changed

// File: rtl/icb_apb_bridge.sv
// icb_apb_bridge: single-outstanding ICB-to-APB3 bridge.
// Handles PREADY wait states, suppresses null writes and ends hung transfers with a timeout error.
module icb_apb_bridge #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT        = 256
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      icb_cmd_valid,
    output logic                      icb_cmd_ready,
    input  logic [31:0]               icb_cmd_addr,
    input  logic                      icb_cmd_read,
    input  logic [31:0]               icb_cmd_wdata,
    input  logic [3:0]                icb_cmd_wmask,
    output logic                      icb_rsp_valid,
    input  logic                      icb_rsp_ready,
    output logic [31:0]               icb_rsp_rdata,
    output logic                      icb_rsp_err,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [31:0]               pwdata_q;
    logic                      pwrite_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      rsp_valid_q;
    logic [31:0]               rsp_rdata_q;
    logic                      rsp_err_q;

    logic cmd_fire_c;
    logic null_wr_c;
    logic timeout_c;
    logic unused_addr;

    assign icb_cmd_ready = (state_q == S_IDLE) & ~RST;
    assign cmd_fire_c    = icb_cmd_valid & icb_cmd_ready;
    assign null_wr_c     = ~icb_cmd_read & (icb_cmd_wmask == 4'h0);
    assign timeout_c     = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Upper address bits are decoded by the fabric; byte offset is dropped.
    assign unused_addr = ^{icb_cmd_addr[31:APB_ADDR_WIDTH], icb_cmd_addr[1:0]};

    assign PADDR         = paddr_q;
    assign PWDATA        = pwdata_q;
    assign PWRITE        = pwrite_q;
    assign PSEL          = psel_q;
    assign PENABLE       = penable_q;
    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_rdata = rsp_rdata_q;
    assign icb_rsp_err   = rsp_err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire_c) begin
                        paddr_q  <= {icb_cmd_addr[APB_ADDR_WIDTH-1:2], 2'b00};
                        pwdata_q <= icb_cmd_wdata;
                        pwrite_q <= ~icb_cmd_read;
                        if (null_wr_c) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= '0;
                            state_q     <= S_RESP;
                        end else begin
                            psel_q  <= 1'b1;
                            state_q <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata_q <= pwrite_q ? 32'h0 : PRDATA;
                        rsp_err_q   <= PSLVERR;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else if (timeout_c) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (icb_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
